// File: rtl/operand_loader_pkg.sv
// operand_loader_pkg
// Shared constants and helpers for the operand loader:
//   NIBBLE_W / OPERAND_W   - switch nibble and operand widths
//   A_LO, A_HI, B_LO, B_HI - nibble slot indices, also the button index
//                            (PB1..PB4 map to slots 0..3)
//   clog2()                - debounce counter width, never below 1 bit
package operand_loader_pkg;

    localparam int NIBBLE_W  = 4;
    localparam int OPERAND_W = 8;
    localparam int NIBBLE_N  = 4;

    localparam int A_LO = 0;
    localparam int A_HI = 1;
    localparam int B_LO = 2;
    localparam int B_HI = 3;

    // Ceiling log2, clamped to 1 so a DEBOUNCE_CYCLES of 1 still gets a
    // legal one-bit counter.
    function automatic int clog2(input int unsigned n);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((32'd1 << i) < n) begin
                r = i + 1;
            end else begin
                r = r;
            end
        end
        if (r < 1) begin
            return 1;
        end else begin
            return r;
        end
    endfunction

endpackage

// File: rtl/operand_loader_if.sv
// operand_loader_if
// Output bundle of the operand loader towards the comparator.
//   a, b            - assembled 8-bit operands (registered in the loader)
//   operands_valid  - one-cycle pulse when all four nibbles are in
//   load_mask       - live loaded-nibble mask  (OPERAND_LOADER_STATUS_EN)
//   pb_stable       - debounced button levels  (OPERAND_LOADER_STATUS_EN)
// Modport master is the loader side, slave the consumer side.
interface operand_loader_if;
    import operand_loader_pkg::*;

    logic [OPERAND_W-1:0] a;
    logic [OPERAND_W-1:0] b;
    logic                 operands_valid;
`ifdef OPERAND_LOADER_STATUS_EN
    logic [NIBBLE_N-1:0]  load_mask;
    logic [NIBBLE_N-1:0]  pb_stable;

    modport master (output a, output b, output operands_valid,
                    output load_mask, output pb_stable);
    modport slave  (input a, input b, input operands_valid,
                    input load_mask, input pb_stable);
`else
    modport master (output a, output b, output operands_valid);
    modport slave  (input a, input b, input operands_valid);
`endif

endinterface

// File: rtl/pb_debounce.sv
// pb_debounce
// One raw pushbutton: SYNC_STAGES-deep synchronizer, mismatch counter
// debouncer, and rising-edge detector on the debounced level.
//   clk, reset - clock, async active-high reset (clears every flop)
//   raw        - asynchronous button level
//   stable     - debounced level (registered)
//   press      - one-cycle pulse the cycle after stable rises (registered)
// A level change is accepted once the synchronized level has disagreed
// with stable for DEBOUNCE_CYCLES consecutive edges; any agreement in
// between restarts the count, so shorter glitches are ignored.
module pb_debounce
    import operand_loader_pkg::*;
#(
    parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
    parameter int          SYNC_STAGES     = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic stable,
    output logic press
);

    localparam int              CNT_W   = clog2(32'(DEBOUNCE_CYCLES));
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 16'd1);

    logic [SYNC_STAGES-1:0] sync_r;
    logic [CNT_W-1:0]       cnt_r;
    logic                   stable_r;
    logic                   stable_d_r;
    logic                   press_r;
    logic                   s_s;

    assign s_s = sync_r[SYNC_STAGES-1];

    // Synchronizer shift chain for the raw button level.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_r <= '0;
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], raw};
        end
    end

    // Mismatch counter; the accepting edge updates stable and clears the count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_r    <= '0;
            stable_r <= 1'b0;
        end else if (s_s == stable_r) begin
            cnt_r    <= '0;
        end else if (cnt_r == CNT_MAX) begin
            cnt_r    <= '0;
            stable_r <= s_s;
        end else begin
            cnt_r    <= cnt_r + CNT_W'(1);
        end
    end

    // Rise detector: press is high the cycle after stable goes 0->1.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stable_d_r <= 1'b0;
            press_r    <= 1'b0;
        end else begin
            stable_d_r <= stable_r;
            press_r    <= stable_r & ~stable_d_r;
        end
    end

    assign stable = stable_r;
    assign press  = press_r;

endmodule

// File: rtl/operand_loader.sv
// operand_loader
// Turns four bouncy pushbuttons and a 4-bit switch bank into two clean
// 8-bit operands for the downstream comparator.
//   clk, reset    - single clock, async active-high reset
//   Y[3:0]        - switch nibble, synchronized here
//   PB1..PB4      - raw buttons loading a[3:0], a[7:4], b[3:0], b[7:4]
//   ops (master)  - a, b, operands_valid, and with
//                   OPERAND_LOADER_STATUS_EN also load_mask, pb_stable
// operands_valid pulses once every nibble has been loaded since the last
// pulse or reset; reloading a nibble overwrites it without extra pulses.
module operand_loader
    import operand_loader_pkg::*;
#(
    parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
    parameter int          SYNC_STAGES     = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NIBBLE_W-1:0] Y,
    input  logic                PB1,
    input  logic                PB2,
    input  logic                PB3,
    input  logic                PB4,
    operand_loader_if.master    ops
);

    logic [NIBBLE_W-1:0]  y_sync_r [SYNC_STAGES];
    logic [NIBBLE_W-1:0]  y_s;
    logic [NIBBLE_N-1:0]  pb_raw_s;
    logic [NIBBLE_N-1:0]  press_s;
    logic [NIBBLE_N-1:0]  mask_r;
    logic [NIBBLE_N-1:0]  mask_next_s;
    logic                 full_s;
    logic [OPERAND_W-1:0] a_r;
    logic [OPERAND_W-1:0] b_r;
    logic                 valid_r;
`ifdef OPERAND_LOADER_STATUS_EN
    logic [NIBBLE_N-1:0]  stable_s;
`endif

    assign pb_raw_s = {PB4, PB3, PB2, PB1};
    assign y_s      = y_sync_r[SYNC_STAGES-1];

    // Synchronizer chain for the switch nibble.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                y_sync_r[i] <= '0;
            end
        end else begin
            y_sync_r[0] <= Y;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                y_sync_r[i] <= y_sync_r[i-1];
            end
        end
    end

    for (genvar i = 0; i < NIBBLE_N; i++) begin : g_pb
        pb_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .SYNC_STAGES     (SYNC_STAGES)
        ) u_pb (
            .clk    (clk),
            .reset  (reset),
            .raw    (pb_raw_s[i]),
            .press  (press_s[i]),
`ifdef OPERAND_LOADER_STATUS_EN
            .stable (stable_s[i])
`else
            .stable ()
`endif
        );
    end

    // Completion looks at the mask including this edge's loads, so
    // simultaneous presses that finish the set give a single pulse.
    always_comb begin
        mask_next_s = mask_r | press_s;
        if (mask_next_s == 4'b1111) begin
            full_s = 1'b1;
        end else begin
            full_s = 1'b0;
        end
    end

    // Nibble loads, loaded-mask bookkeeping and the completion pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_r     <= '0;
            b_r     <= '0;
            mask_r  <= 4'b0000;
            valid_r <= 1'b0;
        end else begin
            if (press_s[A_LO]) begin
                a_r[NIBBLE_W-1:0] <= y_s;
            end
            if (press_s[A_HI]) begin
                a_r[OPERAND_W-1:NIBBLE_W] <= y_s;
            end
            if (press_s[B_LO]) begin
                b_r[NIBBLE_W-1:0] <= y_s;
            end
            if (press_s[B_HI]) begin
                b_r[OPERAND_W-1:NIBBLE_W] <= y_s;
            end
            if (full_s) begin
                mask_r  <= 4'b0000;
                valid_r <= 1'b1;
            end else begin
                mask_r  <= mask_next_s;
                valid_r <= 1'b0;
            end
        end
    end

    assign ops.a              = a_r;
    assign ops.b              = b_r;
    assign ops.operands_valid = valid_r;
`ifdef OPERAND_LOADER_STATUS_EN
    assign ops.load_mask      = mask_r;
    assign ops.pb_stable      = stable_s;
`endif

endmodule

// File: tb/tb_operand_loader.sv
// tb_operand_loader
// Randomized and directed button/switch stimulus against a rule-level
// model of the loader. Stimulus pushes the expected {a,b} of each
// completed set into a queue; a monitor pops it whenever operands_valid
// is seen. Direct checks cover reset state, operand values after each
// press, and press-to-load latency.
module tb_operand_loader;

    localparam logic [15:0] DB = 16'd4;
    localparam int          SS = 2;
    localparam int          DBI = 4;

    logic       clk;
    logic       reset;
    logic [3:0] Y;
    logic       PB1, PB2, PB3, PB4;

    int vectors;
    int miscompares;

    logic [7:0]  m_a, m_b;
    logic [3:0]  m_mask;
    logic [15:0] exp_q [$];
    logic        prev_v;

    operand_loader_if ops_if ();

    operand_loader #(
        .DEBOUNCE_CYCLES (DB),
        .SYNC_STAGES     (SS)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .Y     (Y),
        .PB1   (PB1),
        .PB2   (PB2),
        .PB3   (PB3),
        .PB4   (PB4),
        .ops   (ops_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check8(input string name, input logic [7:0] act, input logic [7:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Model: a press lands its nibbles; a full mask queues one completion.
    task automatic model_load(input logic [3:0] btn, input logic [3:0] yv);
        if (btn[0]) m_a[3:0] = yv;
        if (btn[1]) m_a[7:4] = yv;
        if (btn[2]) m_b[3:0] = yv;
        if (btn[3]) m_b[7:4] = yv;
        m_mask = m_mask | btn;
        if (m_mask == 4'hF) begin
            exp_q.push_back({m_a, m_b});
            m_mask = 4'h0;
        end
    endtask

    task automatic model_reset();
        m_a = 8'h00;
        m_b = 8'h00;
        m_mask = 4'h0;
    endtask

    // Set Y, hold buttons `hold` cycles, release and let the release settle.
    task automatic press(input logic [3:0] btn, input logic [3:0] yv, input int hold);
        @(negedge clk);
        Y = yv;
        repeat (SS + 2) @(negedge clk);
        {PB4, PB3, PB2, PB1} = btn;
        if (hold >= DBI) model_load(btn, yv);
        repeat (hold) @(negedge clk);
        {PB4, PB3, PB2, PB1} = 4'b0000;
        repeat (DBI + SS + 6) @(negedge clk);
        check8("press_a", ops_if.a, m_a);
        check8("press_b", ops_if.b, m_b);
`ifdef OPERAND_LOADER_STATUS_EN
        check8("load_mask", {4'h0, ops_if.load_mask}, {4'h0, m_mask});
        check8("pb_stable", {4'h0, ops_if.pb_stable}, 8'h00);
`endif
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        model_reset();
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Scoreboard monitor: every valid pulse must match the queue head.
    always @(negedge clk) begin
        if (reset) begin
            prev_v <= 1'b0;
        end else begin
            if (ops_if.operands_valid) begin
                if (prev_v) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL pulse_width: valid high %0d cycles, required 1", 2);
                end
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_valid: a=%h b=%h with no completion expected",
                             ops_if.a, ops_if.b);
                end else begin
                    logic [15:0] e;
                    e = exp_q.pop_front();
                    check8("valid_a", ops_if.a, e[15:8]);
                    check8("valid_b", ops_if.b, e[7:0]);
                end
            end
            prev_v <= ops_if.operands_valid;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        vectors = 0;
        miscompares = 0;
        model_reset();
        reset = 1'b1;
        Y = 4'h0;
        {PB4, PB3, PB2, PB1} = 4'b0000;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check8("reset_a", ops_if.a, 8'h00);
        check8("reset_b", ops_if.b, 8'h00);
        check8("reset_valid", {7'h0, ops_if.operands_valid}, 8'h00);

        // In-order presses
        press(4'b0001, 4'h3, 6);
        press(4'b0010, 4'hA, 6);
        press(4'b0100, 4'h5, 6);
        press(4'b1000, 4'hC, 6);
        check8("order_a", ops_if.a, 8'hA3);
        check8("order_b", ops_if.b, 8'hC5);

        // Glitch shorter than the debounce window after a fresh reset
        do_reset();
        press(4'b0001, 4'hF, 3);
        check8("glitch_a", ops_if.a, 8'h00);

        // Reload of an already-set nibble
        press(4'b0001, 4'h1, 5);
        press(4'b0001, 4'h7, 5);
        press(4'b0010, 4'h2, 5);
        press(4'b0100, 4'h4, 5);
        press(4'b1000, 4'h6, 5);
        check8("reload_a", ops_if.a, 8'h27);
        check8("reload_b", ops_if.b, 8'h64);

        // Simultaneous PB3+PB4 finishing the set, with latency measurement
        do_reset();
        press(4'b0001, 4'h1, 5);
        press(4'b0010, 4'h2, 5);
        @(negedge clk);
        Y = 4'h9;
        repeat (SS + 2) @(negedge clk);
        {PB4, PB3, PB2, PB1} = 4'b1100;
        model_load(4'b1100, 4'h9);
        lat = -1;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk);
            #1;
            if (lat < 0 && ops_if.b == 8'h99) lat = k;
        end
        vectors++;
        if (lat != SS + DBI + 1) begin
            miscompares++;
            $display("FAIL latency: load on edge %0d, required %0d", lat, SS + DBI + 1);
        end
        @(negedge clk);
        {PB4, PB3, PB2, PB1} = 4'b0000;
        repeat (DBI + SS + 6) @(negedge clk);
        check8("simul_b", ops_if.b, 8'h99);

        // Reset in the middle of a partial set
        press(4'b0001, 4'h1, 5);
        press(4'b0010, 4'h2, 5);
        do_reset();
        @(negedge clk);
        check8("midreset_a", ops_if.a, 8'h00);
        press(4'b0001, 4'h5, 5);
        press(4'b0010, 4'h5, 5);
        press(4'b0100, 4'h5, 5);
        press(4'b1000, 4'h5, 5);
        check8("midreset_final_a", ops_if.a, 8'h55);
        check8("midreset_final_b", ops_if.b, 8'h55);

        // Status-order walk (mask 0010 then 0110 then cleared)
        press(4'b0010, 4'h8, 5);
        press(4'b0100, 4'h3, 5);
        press(4'b1001, 4'hE, 5);

        // Randomized presses, combinations and glitches
        for (int n = 0; n < 30; n++) begin
            logic [3:0] btn, yv;
            int hold;
            btn = 4'($urandom_range(1, 15));
            yv = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 4) == 0) hold = $urandom_range(1, DBI - 1);
            else hold = $urandom_range(DBI, DBI + 8);
            press(btn, yv, hold);
        end

        repeat (10) @(negedge clk);
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL missing_valid: %0d completions never seen, required 0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
